pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter and address width.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have ports clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-004 SHALL have ports start in 1, leave IDLE; halt in 1, stop after current instruction.
REQ-005 SHALL have ports imem_req out 1, fetch request; imem_ack in 1, fetch complete.
REQ-006 SHALL have ports ir_load out 1, instruction-register load pulse; alu_start out 1, execute pulse; alu_done in 1, execute complete.
REQ-007 SHALL have ports is_branch in 1; unconditional in 1; conditional in 3, per-flag condition mask; ad_sel in 1, target select.
REQ-008 SHALL have ports address in PC_W, immediate target; res in PC_W, ALU-result target.
REQ-009 SHALL have ports alu_flags in 3; flag_we in 1, latch alu_flags at commit.
REQ-010 SHALL have ports pc out PC_W; flags out 3; busy out 1; state out 3; taken_cnt out 32.

Function
REQ-011 SHALL implement FSM IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED; state output encodes 0..5 in that order.
REQ-012 IDLE: start=1 -> FETCH next edge; otherwise hold.
REQ-013 FETCH: imem_req=1 every cycle; imem_ack=1 -> DECODE next edge; no timeout.
REQ-014 DECODE: ir_load=1 for exactly one cycle; -> EXEC.
REQ-015 EXEC: alu_start=1 on first EXEC cycle only; stay until alu_done=1, then -> UPDATE; alu_done sampled in the same cycle as alu_start counts.
REQ-016 UPDATE (one cycle): taken = is_branch & (unconditional | |(conditional & flags)); pc <= taken ? (ad_sel ? res : address) : pc+1, modulo 2^PC_W.
REQ-017 Branch condition SHALL use the flags register value held before this UPDATE edge; if flag_we=1, flags <= alu_flags on the same edge.
REQ-018 UPDATE -> HALTED if halt=1 was seen in any cycle since leaving IDLE or in UPDATE itself, else -> FETCH.
REQ-019 HALTED: hold all state; only rst exits; start ignored.
REQ-020 busy SHALL be 1 in FETCH, DECODE, EXEC, UPDATE; 0 in IDLE, HALTED.
REQ-021 pc, flags SHALL change only on an UPDATE edge or reset.
REQ-022 Branch inputs SHALL be sampled only in UPDATE; values in other states are ignored.

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, pc=RESET_PC, flags=0, taken_cnt=0, pending halt=0, imem_req/ir_load/alu_start=0.
REQ-024 rst asserted mid-FETCH or mid-EXEC SHALL drop imem_req/alu_start immediately; late imem_ack/alu_done after release SHALL be ignored in IDLE.

Configuration
REQ-025 With PC_SEQ_PERF_CNT_EN defined, taken_cnt SHALL increment by 1 on every UPDATE edge where taken=1, wrapping at 2^32.
REQ-026 Without PC_SEQ_PERF_CNT_EN, taken_cnt SHALL be constant 0 and no counter register synthesized.

Structure
REQ-027 State encoding constants and flag bit positions (0 zero, 1 sign, 2 carry) SHALL live in shared package cpu_pkg.
REQ-028 Next-address selection SHALL be a single combinational sub-module, jump_unit, instantiated once.

Verification
REQ-029 Reset, start, imem_ack after 2 cycles, alu_done after 1, is_branch=0 -> pc 0 -> 1; taken_cnt 0.
REQ-030 pc=2, is_branch=1, unconditional=1, ad_sel=0, address=35 -> pc=35 after UPDATE; taken_cnt=1 when PC_SEQ_PERF_CNT_EN.
REQ-031 flags=3'b001, conditional=3'b001, ad_sel=1, res=45 -> pc=45; same with flags=3'b000 -> pc+1.
REQ-032 Branch with conditional=3'b010, flags=0, flag_we=1, alu_flags=3'b010 in same UPDATE -> not taken; flags=3'b010 afterwards.
REQ-033 halt pulsed during EXEC -> UPDATE completes, state HALTED, busy=0; start ignored.
REQ-034 rst asserted mid-FETCH -> imem_req=0 without clock edge, pc=RESET_PC, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared sequencer definitions: FSM state encoding and ALU flag bit positions.
package cpu_pkg;

  localparam int NFLAGS = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALTED = 3'd5
  } state_t;

endpackage

// File: rtl/pc_sequencer_jump_unit.sv
// Next-PC selection: branch decision from flags/condition mask, target mux, pc+1 fallthrough.
module jump_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0]   pc,
  input  logic              is_branch,
  input  logic              unconditional,
  input  logic [NFLAGS-1:0] conditional,
  input  logic [NFLAGS-1:0] flags,
  input  logic              ad_sel,
  input  logic [PC_W-1:0]   address,
  input  logic [PC_W-1:0]   res,
  output logic              taken,
  output logic [PC_W-1:0]   next_pc
);

  assign taken   = is_branch & (unconditional | (|(conditional & flags)));
  assign next_pc = taken ? (ad_sel ? res : address) : pc + PC_W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer FSM: fetch/decode/exec/update with PC and flag registers.
// Define PC_SEQ_PERF_CNT_EN to build the taken-branch counter (taken_cnt is 0 otherwise).
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              ir_load,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic              is_branch,
  input  logic              unconditional,
  input  logic [NFLAGS-1:0] conditional,
  input  logic              ad_sel,
  input  logic [PC_W-1:0]   address,
  input  logic [PC_W-1:0]   res,
  input  logic [NFLAGS-1:0] alu_flags,
  input  logic              flag_we,
  output logic [PC_W-1:0]   pc,
  output logic [NFLAGS-1:0] flags,
  output logic              busy,
  output logic [2:0]        state,
  output logic [31:0]       taken_cnt
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              halt_pend_q, halt_pend_d;
  logic              imem_req_q, imem_req_d;
  logic              ir_load_q, ir_load_d;
  logic              alu_start_q, alu_start_d;
  logic              taken;
  logic [PC_W-1:0]   next_pc;

  jump_unit #(.PC_W(PC_W)) u_jump (
    .pc(pc_q), .is_branch(is_branch), .unconditional(unconditional),
    .conditional(conditional), .flags(flags_q), .ad_sel(ad_sel),
    .address(address), .res(res), .taken(taken), .next_pc(next_pc)
  );

  // Strobe outputs are registered, so they are set on the edge entering their state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    halt_pend_d = halt_pend_q;
    imem_req_d  = 1'b0;
    ir_load_d   = 1'b0;
    alu_start_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
      end
      S_FETCH: begin
        halt_pend_d = halt_pend_q | halt;
        if (imem_ack) begin
          state_d   = S_DECODE;
          ir_load_d = 1'b1;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        halt_pend_d = halt_pend_q | halt;
        state_d     = S_EXEC;
        alu_start_d = 1'b1;
      end
      S_EXEC: begin
        halt_pend_d = halt_pend_q | halt;
        if (alu_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        pc_d = next_pc;
        if (flag_we) flags_d = alu_flags;
        if (halt_pend_q | halt) begin
          state_d = S_HALTED;
        end else begin
          state_d     = S_FETCH;
          imem_req_d  = 1'b1;
          halt_pend_d = 1'b0;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      flags_q     <= '0;
      halt_pend_q <= 1'b0;
      imem_req_q  <= 1'b0;
      ir_load_q   <= 1'b0;
      alu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flags_q     <= flags_d;
      halt_pend_q <= halt_pend_d;
      imem_req_q  <= imem_req_d;
      ir_load_q   <= ir_load_d;
      alu_start_q <= alu_start_d;
    end
  end

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (state_q == S_UPDATE && taken) taken_cnt_d = taken_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) taken_cnt_q <= '0;
    else     taken_cnt_q <= taken_cnt_d;
  end

  assign taken_cnt = taken_cnt_q;
`else
  logic unused_taken;
  assign unused_taken = taken;
  assign taken_cnt    = '0;
`endif

  assign pc        = pc_q;
  assign flags     = flags_q;
  assign state     = state_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC)  || (state_q == S_UPDATE);
  assign imem_req  = imem_req_q;
  assign ir_load   = ir_load_q;
  assign alu_start = alu_start_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch/exec handshakes, branch selection, flags, halt, reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halt, imem_ack, alu_done;
  logic        is_branch, unconditional, ad_sel, flag_we;
  logic [2:0]  conditional, alu_flags;
  logic [31:0] address, res;
  logic        imem_req, ir_load, alu_start, busy;
  logic [31:0] pc, taken_cnt;
  logic [2:0]  flags, state;

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_load(ir_load), .alu_start(alu_start), .alu_done(alu_done),
    .is_branch(is_branch), .unconditional(unconditional), .conditional(conditional),
    .ad_sel(ad_sel), .address(address), .res(res),
    .alu_flags(alu_flags), .flag_we(flag_we),
    .pc(pc), .flags(flags), .busy(busy), .state(state), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entry in FETCH; returns in UPDATE. halt_exec pulses halt in the first EXEC cycle only.
  task automatic do_instr(input int ack_wait, input int done_wait, input logic halt_exec);
    repeat (ack_wait) step();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    halt = halt_exec;
    repeat (done_wait) begin
      step();
      halt = 1'b0;
    end
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    halt     = 1'b0;
  endtask

  task automatic upd(input logic br, input logic unc, input logic [2:0] cond, input logic sel,
                     input logic [31:0] adr, input logic [31:0] rs,
                     input logic we, input logic [2:0] af);
    is_branch = br; unconditional = unc; conditional = cond; ad_sel = sel;
    address = adr; res = rs; flag_we = we; alu_flags = af;
    step();
    is_branch = 1'b0; unconditional = 1'b0; conditional = '0; ad_sel = 1'b0;
    address = '0; res = '0; flag_we = 1'b0; alu_flags = '0;
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef PC_SEQ_PERF_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; imem_ack = 1'b0; alu_done = 1'b0;
    is_branch = 1'b0; unconditional = 1'b0; conditional = '0; ad_sel = 1'b0;
    address = '0; res = '0; flag_we = 1'b0; alu_flags = '0;
    step();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_cnt", taken_cnt, 0);
    rst = 1'b0;
    step();
    chk("idle_hold", state, 0);

    // Plain instruction, ack after 2 cycles, done after 1, walking each state.
    start = 1'b1; step(); start = 1'b0;
    chk("fetch_state", state, 1);
    chk("fetch_req", imem_req, 1);
    chk("fetch_busy", busy, 1);
    step();
    chk("fetch_req2", imem_req, 1);
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    chk("dec_state", state, 2);
    chk("dec_irload", ir_load, 1);
    chk("dec_req", imem_req, 0);
    step();
    chk("exec_state", state, 3);
    chk("exec_start", alu_start, 1);
    chk("exec_irload", ir_load, 0);
    step();
    chk("exec_start2", alu_start, 0);
    chk("exec_hold", state, 3);
    alu_done = 1'b1; step(); alu_done = 1'b0;
    chk("upd_state", state, 4);
    chk("upd_pc_hold", pc, 0);
    upd(0, 0, 3'b000, 0, 32'd99, 32'd77, 0, 3'b000);
    chk("seq_pc1", pc, 1);
    chk("seq_state", state, 1);
    chk("seq_cnt", taken_cnt, 0);

    // alu_done already high on the alu_start cycle.
    do_instr(0, 0, 0);
    chk("fast_upd", state, 4);
    upd(0, 1, 3'b111, 0, 32'd99, 32'd77, 0, 3'b000);
    chk("nobr_pc2", pc, 2);

    do_instr(1, 2, 0);
    upd(1, 1, 3'b000, 0, 32'd35, 32'd77, 0, 3'b000);
    chk("unc_pc35", pc, 35);
    chk("unc_cnt", taken_cnt, exp_cnt(1));

    do_instr(0, 1, 0);
    upd(0, 0, 3'b000, 0, 32'd0, 32'd0, 1, 3'b001);
    chk("setz_pc", pc, 36);
    chk("setz_flags", flags, 3'b001);

    do_instr(0, 1, 0);
    upd(1, 0, 3'b001, 1, 32'd99, 32'd45, 0, 3'b000);
    chk("condz_pc45", pc, 45);
    chk("condz_cnt", taken_cnt, exp_cnt(2));

    do_instr(0, 1, 0);
    upd(0, 0, 3'b000, 0, 32'd0, 32'd0, 1, 3'b000);
    chk("clrz_flags", flags, 0);
    do_instr(0, 1, 0);
    upd(1, 0, 3'b001, 1, 32'd99, 32'd45, 0, 3'b000);
    chk("condz_nt_pc", pc, 47);

    // Condition must use the flags before this edge, not the ones being written.
    do_instr(0, 1, 0);
    upd(1, 0, 3'b010, 0, 32'd200, 32'd0, 1, 3'b010);
    chk("oldflag_pc", pc, 48);
    chk("oldflag_flags", flags, 3'b010);
    chk("oldflag_cnt", taken_cnt, exp_cnt(2));

    do_instr(0, 1, 0);
    upd(1, 1, 3'b000, 0, 32'hFFFF_FFFF, 32'd0, 0, 3'b000);
    chk("max_pc", pc, 32'hFFFF_FFFF);
    do_instr(0, 1, 0);
    upd(0, 0, 3'b000, 0, 32'd5, 32'd5, 0, 3'b000);
    chk("wrap_pc", pc, 0);
    chk("wrap_cnt", taken_cnt, exp_cnt(3));

    // Halt pulse in EXEC is remembered until UPDATE.
    do_instr(0, 1, 1);
    chk("halt_upd", state, 4);
    upd(0, 0, 3'b000, 0, 32'd0, 32'd0, 0, 3'b000);
    chk("halt_state", state, 5);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 1);
    start = 1'b1; imem_ack = 1'b1; alu_done = 1'b1;
    step(); step();
    start = 1'b0; imem_ack = 1'b0; alu_done = 1'b0;
    chk("halt_stay", state, 5);
    chk("halt_pc_hold", pc, 1);
    chk("halt_req", imem_req, 0);

    // Asynchronous reset mid-FETCH.
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    do_instr(0, 1, 0);
    upd(0, 0, 3'b000, 0, 32'd0, 32'd0, 1, 3'b100);
    chk("pre_rst_pc", pc, 1);
    chk("pre_rst_req", imem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_state", state, 0);
    chk("arst_pc", pc, 0);
    chk("arst_flags", flags, 0);
    step();
    rst = 1'b0;
    imem_ack = 1'b1; alu_done = 1'b1;
    step();
    imem_ack = 1'b0; alu_done = 1'b0;
    chk("late_ack_idle", state, 0);
    chk("late_ack_req", imem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
